param_assoc_cache: RTL and testbench

- Parametrised successor to the direct-mapped cache: ASSOC-way set-associative (ASSOC = 1 or 2) with configurable set count and block size.
- Contains its own miss-handling FSM: block fill from memory, write-through with no-write-allocate, per-set LRU replacement.
- Sits between a CPU pipeline stage (fetch or memory) and the memory arbiter.
- Supports one outstanding request.

---
 rtl/param_assoc_cache_if.sv | 31 +++
 rtl/param_assoc_cache.sv | 232 +++++++++++++++++++++++
 tb/tb_param_assoc_cache.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_assoc_cache_if.sv
// CPU-side request bus plus memory-side fill and write-through bus of the cache.
// The cache binds to the slave modport; the CPU stage or arbiter binds to master.
interface param_assoc_cache_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic [DATA_W-1:0] rdata;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rd_data, mem_rd_valid, mem_wr_ack,
        output req_ready, rdata, mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rd_data, mem_rd_valid, mem_wr_ack,
        input  req_ready, rdata, mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/param_assoc_cache.sv
// ASSOC-way set-associative cache (1 or 2 ways) with block fill on read miss,
// write-through with no-write-allocate, and one LRU bit per set.
module param_assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int ASSOC  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    param_assoc_cache_if.slave bus,
    output logic [15:0]        miss_count
);
    localparam int OFF   = $clog2(WORDS);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF - IDX - 1;
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WT   = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic [DATA_W-1:0] data_mem [ASSOC][SETS][WORDS];
    logic [TAG_W-1:0]  tag_mem  [ASSOC][SETS];
    logic [SETS-1:0]   valid_r  [ASSOC];
    // lru_r[set] names the way to evict next when both ways are valid
    logic [SETS-1:0]   lru_r;
    logic [OFF-1:0]    cnt_r;
    logic              victim_r;
    logic [ADDR_W-1:0] mem_rd_addr_r;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [DATA_W-1:0] mem_wr_data_r;

    logic [OFF-1:0]    req_word_s;
    logic [IDX-1:0]    req_idx_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX-1:0]    fill_idx_s;
    logic [TAG_W-1:0]  fill_tag_s;
    logic [ASSOC-1:0]  match_s;
    logic              hit_s;
    logic              hit_way_s;
    logic [DATA_W-1:0] hit_word_s;
    logic              victim_s;
    logic              ready_s;
    logic              rd_req_s;
    logic              wr_req_s;
    logic              dwe_s;
    logic              twe_s;
    logic              dway_s;
    logic [IDX-1:0]    didx_s;
    logic [OFF-1:0]    dword_s;
    logic [DATA_W-1:0] ddata_s;
    logic              unused_s;

    assign req_word_s = bus.req_addr[OFF:1];
    assign req_idx_s  = bus.req_addr[OFF+IDX:OFF+1];
    assign req_tag_s  = bus.req_addr[ADDR_W-1:OFF+IDX+1];
    // The fill targets the latched block address so it is independent of the CPU bus
    assign fill_idx_s = mem_rd_addr_r[OFF+IDX:OFF+1];
    assign fill_tag_s = mem_rd_addr_r[ADDR_W-1:OFF+IDX+1];
    assign unused_s   = &{1'b0, bus.req_addr[0]};

    for (genvar g = 0; g < ASSOC; g++) begin : g_match
        assign match_s[g] = valid_r[g][req_idx_s] && (tag_mem[g][req_idx_s] == req_tag_s);
    end

    assign hit_s      = |match_s;
    assign hit_way_s  = (ASSOC > 1) ? match_s[ASSOC-1] : 1'b0;
    assign hit_word_s = data_mem[hit_way_s][req_idx_s][req_word_s];

    assign bus.req_ready   = ready_s;
    assign bus.rdata       = hit_s ? hit_word_s : {DATA_W{1'b0}};
    assign bus.mem_rd_req  = rd_req_s;
    assign bus.mem_rd_addr = mem_rd_addr_r;
    assign bus.mem_wr_req  = wr_req_s;
    assign bus.mem_wr_addr = mem_wr_addr_r;
    assign bus.mem_wr_data = mem_wr_data_r;

    // Victim choice: first invalid way (way 0 first), otherwise the LRU way
    always_comb begin
        if (ASSOC == 1) begin
            victim_s = 1'b0;
        end else if (!valid_r[0][req_idx_s]) begin
            victim_s = 1'b0;
        end else if (!valid_r[ASSOC-1][req_idx_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[req_idx_s];
        end
    end

    // Miss-handling FSM: next state and handshake outputs
    always_comb begin
        state_s  = state_r;
        ready_s  = 1'b0;
        rd_req_s = 1'b0;
        wr_req_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        state_s = WT;
                    end else if (hit_s) begin
                        ready_s = 1'b1;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                rd_req_s = 1'b1;
                if (bus.mem_rd_valid && (cnt_r == LAST_BEAT)) begin
                    state_s = IDLE;
                end else begin
                    state_s = FILL;
                end
            end
            WT: begin
                wr_req_s = 1'b1;
                if (bus.mem_wr_ack) begin
                    ready_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Data/tag array write port: CPU write hit in IDLE or fill beat in FILL
    always_comb begin
        dwe_s   = 1'b0;
        twe_s   = 1'b0;
        dway_s  = victim_r;
        didx_s  = fill_idx_s;
        dword_s = cnt_r;
        ddata_s = bus.mem_rd_data;
        case (state_r)
            IDLE: begin
                if (bus.req_valid && bus.req_we && hit_s) begin
                    dwe_s   = 1'b1;
                    dway_s  = hit_way_s;
                    didx_s  = req_idx_s;
                    dword_s = req_word_s;
                    ddata_s = bus.req_wdata;
                end else begin
                    dwe_s = 1'b0;
                end
            end
            FILL: begin
                dwe_s = bus.mem_rd_valid;
                twe_s = bus.mem_rd_valid && (cnt_r == LAST_BEAT);
            end
            default: begin
                dwe_s = 1'b0;
            end
        endcase
    end

    // Data and tag storage; contents survive reset, validity is tracked separately
    always_ff @(posedge clk) begin
        if (dwe_s) begin
            data_mem[dway_s][didx_s][dword_s] <= ddata_s;
        end
        if (twe_s) begin
            tag_mem[victim_r][fill_idx_s] <= fill_tag_s;
        end
    end

    // Control state, valid/LRU bits, miss counter and latched memory addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            victim_r      <= 1'b0;
            lru_r         <= '0;
            miss_count    <= 16'd0;
            mem_rd_addr_r <= '0;
            mem_wr_addr_r <= '0;
            mem_wr_data_r <= '0;
            for (int w = 0; w < ASSOC; w++) begin
                valid_r[w] <= '0;
            end
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid && !bus.req_we && !hit_s) begin
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                        mem_rd_addr_r <= {bus.req_addr[ADDR_W-1:OFF+1], {(OFF+1){1'b0}}};
                        cnt_r         <= '0;
                        victim_r      <= victim_s;
                        // Drop the victim now so an aborted fill never leaves a stale hit
                        valid_r[victim_s][req_idx_s] <= 1'b0;
                    end else if (bus.req_valid && bus.req_we) begin
                        mem_wr_addr_r <= bus.req_addr;
                        mem_wr_data_r <= bus.req_wdata;
                    end
                    if ((ASSOC > 1) && bus.req_valid && hit_s) begin
                        lru_r[req_idx_s] <= ~hit_way_s;
                    end
                end
                FILL: begin
                    if (bus.mem_rd_valid) begin
                        cnt_r <= cnt_r + OFF'(1);
                        if (cnt_r == LAST_BEAT) begin
                            valid_r[victim_r][fill_idx_s] <= 1'b1;
                            if (ASSOC > 1) begin
                                lru_r[fill_idx_s] <= ~victim_r;
                            end
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_param_assoc_cache.sv
// Directed bench for param_assoc_cache (default parameters): fills, hits, LRU
// eviction, write-through hit/miss and reset in the middle of a fill.
module tb_param_assoc_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] miss_count;
    int          total = 0;
    int          bad   = 0;

    param_assoc_cache_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    param_assoc_cache #(
        .ADDR_W(16), .DATA_W(16), .SETS(64), .WORDS(8), .ASSOC(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic end_req();
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic fill_beats(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = base + 16'(i);
            step();
        end
        bus.mem_rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
        bus.mem_rd_valid = 1'b0; bus.mem_rd_data = 16'h0; bus.mem_wr_ack = 1'b0;
        #12;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0h want 0", bus.req_ready); end
        total++; if (bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL rst_rd_req: got %0h want 0", bus.mem_rd_req); end
        total++; if (bus.mem_wr_req !== 1'b0) begin bad++; $display("FAIL rst_wr_req: got %0h want 0", bus.mem_wr_req); end
        total++; if (bus.rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata: got %0h want 0", bus.rdata); end
        total++; if (miss_count !== 16'h0) begin bad++; $display("FAIL rst_miss: got %0h want 0", miss_count); end
        total++; if ({bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data} !== 48'h0) begin
            bad++; $display("FAIL rst_mem_regs: got %0h/%0h/%0h want 0", bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_miss_fill();
        start_req(1'b0, 16'h1234, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL miss_ready: got %0h want 0", bus.req_ready); end
        total++; if (bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL miss_rd_req_idle: got %0h want 0", bus.mem_rd_req); end
        step();
        @(negedge clk);
        total++; if (bus.mem_rd_req !== 1'b1) begin bad++; $display("FAIL miss_rd_req: got %0h want 1", bus.mem_rd_req); end
        total++; if (bus.mem_rd_addr !== 16'h1230) begin bad++; $display("FAIL miss_rd_addr: got %0h want 1230", bus.mem_rd_addr); end
        total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL miss_count1: got %0d want 1", miss_count); end
        fill_beats(16'hA000, 7);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL miss_ready_mid: got %0h want 0", bus.req_ready); end
        fill_beats(16'hA007, 1);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL fill_ready: got %0h want 1", bus.req_ready); end
        total++; if (bus.rdata !== 16'hA002) begin bad++; $display("FAIL fill_rdata: got %0h want a002", bus.rdata); end
        total++; if (bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL fill_rd_req_drop: got %0h want 0", bus.mem_rd_req); end
        end_req();
    endtask

    task automatic test_read_hit();
        start_req(1'b0, 16'h1236, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL hit_ready: got %0h want 1", bus.req_ready); end
        total++; if (bus.rdata !== 16'hA003) begin bad++; $display("FAIL hit_rdata: got %0h want a003", bus.rdata); end
        total++; if (bus.mem_rd_req !== 1'b0) begin bad++; $display("FAIL hit_rd_req: got %0h want 0", bus.mem_rd_req); end
        end_req();
        total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL hit_miss_count: got %0d want 1", miss_count); end
    endtask

    task automatic test_lru();
        // 0x5234: same set 0x23, fills way 1
        start_req(1'b0, 16'h5234, 16'h0);
        step();
        fill_beats(16'hB000, 8);
        @(negedge clk);
        total++; if (bus.rdata !== 16'hB002) begin bad++; $display("FAIL lru_fill2_rdata: got %0h want b002", bus.rdata); end
        end_req();
        // 0x1234 still resident in way 0, making way 1 the LRU way
        start_req(1'b0, 16'h1234, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.rdata !== 16'hA002) begin
            bad++; $display("FAIL lru_hit_way0: got ready=%0h rdata=%0h want 1/a002", bus.req_ready, bus.rdata);
        end
        end_req();
        // 0x9234 evicts 0x5234
        start_req(1'b0, 16'h9234, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL lru_miss3_ready: got %0h want 0", bus.req_ready); end
        step();
        @(negedge clk);
        total++; if (miss_count !== 16'd3) begin bad++; $display("FAIL lru_miss_count3: got %0d want 3", miss_count); end
        fill_beats(16'hC000, 8);
        @(negedge clk);
        total++; if (bus.rdata !== 16'hC002) begin bad++; $display("FAIL lru_fill3_rdata: got %0h want c002", bus.rdata); end
        end_req();
        start_req(1'b0, 16'h1234, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.rdata !== 16'hA002) begin
            bad++; $display("FAIL lru_keep_way0: got ready=%0h rdata=%0h want 1/a002", bus.req_ready, bus.rdata);
        end
        end_req();
        start_req(1'b0, 16'h5234, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL lru_evicted_ready: got %0h want 0", bus.req_ready); end
        step();
        @(negedge clk);
        total++; if (bus.mem_rd_req !== 1'b1 || miss_count !== 16'd4) begin
            bad++; $display("FAIL lru_evicted_miss: got rd_req=%0h count=%0d want 1/4", bus.mem_rd_req, miss_count);
        end
        fill_beats(16'hD000, 8);
        @(negedge clk);
        total++; if (bus.rdata !== 16'hD002) begin bad++; $display("FAIL lru_refill_rdata: got %0h want d002", bus.rdata); end
        end_req();
    endtask

    task automatic test_write_hit();
        start_req(1'b1, 16'h1236, 16'hBEEF);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL wh_ready_idle: got %0h want 0", bus.req_ready); end
        step();
        @(negedge clk);
        total++; if (bus.mem_wr_req !== 1'b1) begin bad++; $display("FAIL wh_wr_req: got %0h want 1", bus.mem_wr_req); end
        total++; if (bus.mem_wr_addr !== 16'h1236 || bus.mem_wr_data !== 16'hBEEF) begin
            bad++; $display("FAIL wh_wr_bus: got %0h/%0h want 1236/beef", bus.mem_wr_addr, bus.mem_wr_data);
        end
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL wh_ready_wait: got %0h want 0", bus.req_ready); end
        step();
        step();
        bus.mem_wr_ack = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL wh_ack_ready: got %0h want 1", bus.req_ready); end
        end_req();
        bus.mem_wr_ack = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_wr_req !== 1'b0) begin bad++; $display("FAIL wh_wr_req_drop: got %0h want 0", bus.mem_wr_req); end
        step();
        start_req(1'b0, 16'h1236, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.rdata !== 16'hBEEF) begin
            bad++; $display("FAIL wh_readback: got ready=%0h rdata=%0h want 1/beef", bus.req_ready, bus.rdata);
        end
        end_req();
    endtask

    task automatic test_write_miss();
        start_req(1'b1, 16'h7000, 16'h1111);
        step();
        bus.mem_wr_ack = 1'b1;
        @(negedge clk);
        total++; if (bus.mem_wr_addr !== 16'h7000 || bus.mem_wr_data !== 16'h1111) begin
            bad++; $display("FAIL wm_wr_bus: got %0h/%0h want 7000/1111", bus.mem_wr_addr, bus.mem_wr_data);
        end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL wm_ready: got %0h want 1", bus.req_ready); end
        end_req();
        bus.mem_wr_ack = 1'b0;
        start_req(1'b0, 16'h7000, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL wm_no_alloc: got %0h want 0", bus.req_ready); end
        step();
        @(negedge clk);
        total++; if (miss_count !== 16'd5 || bus.mem_rd_addr !== 16'h7000) begin
            bad++; $display("FAIL wm_read_miss: got count=%0d addr=%0h want 5/7000", miss_count, bus.mem_rd_addr);
        end
        fill_beats(16'hE000, 8);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.rdata !== 16'hE000) begin
            bad++; $display("FAIL wm_fill_rdata: got ready=%0h rdata=%0h want 1/e000", bus.req_ready, bus.rdata);
        end
        end_req();
    endtask

    task automatic test_reset_mid_fill();
        start_req(1'b0, 16'h2468, 16'h0);
        step();
        fill_beats(16'h9000, 3);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_rd_req !== 1'b0 || bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst_reqs: got rd_req=%0h ready=%0h want 0/0", bus.mem_rd_req, bus.req_ready);
        end
        total++; if (miss_count !== 16'd0 || bus.mem_rd_addr !== 16'h0) begin
            bad++; $display("FAIL mid_rst_regs: got count=%0d addr=%0h want 0/0", miss_count, bus.mem_rd_addr);
        end
        bus.req_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        start_req(1'b0, 16'h2468, 16'h0);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_remiss: got %0h want 0", bus.req_ready); end
        step();
        @(negedge clk);
        total++; if (bus.mem_rd_req !== 1'b1 || bus.mem_rd_addr !== 16'h2460 || miss_count !== 16'd1) begin
            bad++; $display("FAIL mid_rst_refill: got rd_req=%0h addr=%0h count=%0d want 1/2460/1",
                            bus.mem_rd_req, bus.mem_rd_addr, miss_count);
        end
        fill_beats(16'hF000, 7);
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_7beats: got %0h want 0", bus.req_ready); end
        fill_beats(16'hF007, 1);
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.rdata !== 16'hF004) begin
            bad++; $display("FAIL mid_rst_rdata: got ready=%0h rdata=%0h want 1/f004", bus.req_ready, bus.rdata);
        end
        end_req();
    endtask

    initial begin
        test_reset();
        test_read_miss_fill();
        test_read_hit();
        test_lru();
        test_write_hit();
        test_write_miss();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
